// File: rtl/div_result_bcd_formatter.sv
// rtl/div_result_bcd_formatter.sv - signed quotient/remainder to sign + packed BCD formatter
//
// Purpose:
//   Sits behind the signed slow divider. One quotient/remainder pair is captured
//   per transaction and each value is turned into a sign bit plus a packed BCD
//   magnitude. The conversion is a sequential double-dabble that handles one
//   magnitude bit per clock on both values at the same time. A divide-by-zero
//   result skips the conversion and is reported through err.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     divider result valid
//   in_ready     formatter idle and able to accept a result
//   quotient     signed quotient, WIDTH bits
//   remainder    signed remainder, WIDTH bits
//   div_by_zero  divisor was zero; quotient/remainder are ignored
//   out_valid    formatted result available
//   out_ready    consumer accepts the result
//   q_sign       1 = quotient negative
//   q_bcd        quotient magnitude, packed BCD, digit 0 in [3:0]
//   r_sign       1 = remainder negative
//   r_bcd        remainder magnitude, packed BCD, digit 0 in [3:0]
//   err          result came from a divide-by-zero

module div_result_bcd_formatter #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      quotient,
    input  logic [WIDTH-1:0]      remainder,
    input  logic                  div_by_zero,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  q_sign,
    output logic [4*DIGITS-1:0]   q_bcd,
    output logic                  r_sign,
    output logic [4*DIGITS-1:0]   r_bcd,
    output logic                  err
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   q_mag_q, q_mag_d;
    logic [WIDTH-1:0]   r_mag_q, r_mag_d;
    logic [BW-1:0]      q_bcd_q, q_bcd_d;
    logic [BW-1:0]      r_bcd_q, r_bcd_d;
    logic               q_sign_q, q_sign_d;
    logic               r_sign_q, r_sign_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    // Double-dabble correction: any digit of 5 or more would become >= 10
    // after the next shift, so it is pre-biased by 3 to carry correctly.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
        logic [BW-1:0] o;
        o = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                o[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return o;
    endfunction

    // Unsigned magnitude; the most negative value maps to 2**(WIDTH-1),
    // which still fits in WIDTH unsigned bits.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? ((~x) + ONE_W) : x;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            q_mag_q  <= '0;
            r_mag_q  <= '0;
            q_bcd_q  <= '0;
            r_bcd_q  <= '0;
            q_sign_q <= 1'b0;
            r_sign_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            q_mag_q  <= q_mag_d;
            r_mag_q  <= r_mag_d;
            q_bcd_q  <= q_bcd_d;
            r_bcd_q  <= r_bcd_d;
            q_sign_q <= q_sign_d;
            r_sign_q <= r_sign_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_mag_d  = q_mag_q;
        r_mag_d  = r_mag_q;
        q_bcd_d  = q_bcd_q;
        r_bcd_d  = r_bcd_q;
        q_sign_d = q_sign_q;
        r_sign_d = r_sign_q;
        err_d    = err_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                    q_bcd_d = '0;
                    r_bcd_d = '0;
                    if (div_by_zero) begin
                        err_d    = 1'b1;
                        q_sign_d = 1'b0;
                        r_sign_d = 1'b0;
                        q_mag_d  = '0;
                        r_mag_d  = '0;
                    end else begin
                        // A set MSB always means a non-zero value, so a zero
                        // magnitude can never carry a negative sign here.
                        err_d    = 1'b0;
                        q_sign_d = quotient[WIDTH-1];
                        r_sign_d = remainder[WIDTH-1];
                        q_mag_d  = abs_mag(quotient);
                        r_mag_d  = abs_mag(remainder);
                    end
                end
            end

            S_CONV: begin
                // One settling cycle after the last shift keeps the accept to
                // out_valid latency at WIDTH+1; an error result has nothing to
                // convert and leaves after that single cycle.
                if (err_q || (cnt_q == CNT_LAST)) begin
                    state_d = S_DONE;
                end else begin
                    {q_bcd_d, q_mag_d} = {add3(q_bcd_q), q_mag_q} << 1;
                    {r_bcd_d, r_mag_d} = {add3(r_bcd_q), r_mag_q} << 1;
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign q_sign    = q_sign_q;
    assign q_bcd     = q_bcd_q;
    assign r_sign    = r_sign_q;
    assign r_bcd     = r_bcd_q;
    assign err       = err_q;

endmodule

// File: tb/tb_div_result_bcd_formatter.sv
// tb/tb_div_result_bcd_formatter.sv - self-checking bench for div_result_bcd_formatter
module tb_div_result_bcd_formatter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        div_by_zero = 1'b0;
    logic        out_ready = 1'b0;
    logic        use8 = 1'b0;
    logic [15:0] q_in = '0;
    logic [15:0] r_in = '0;

    always #5 clk = ~clk;

    logic       in_ready4, out_valid4, q_sign4, r_sign4, err4;
    logic [7:0] q_bcd4, r_bcd4;
    logic       in_ready8, out_valid8, q_sign8, r_sign8, err8;
    logic [11:0] q_bcd8, r_bcd8;

    div_result_bcd_formatter #(.WIDTH(4), .DIGITS(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~use8), .in_ready(in_ready4),
        .quotient(q_in[3:0]), .remainder(r_in[3:0]), .div_by_zero(div_by_zero),
        .out_valid(out_valid4), .out_ready(out_ready), .q_sign(q_sign4), .q_bcd(q_bcd4),
        .r_sign(r_sign4), .r_bcd(r_bcd4), .err(err4)
    );

    div_result_bcd_formatter #(.WIDTH(8), .DIGITS(3)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & use8), .in_ready(in_ready8),
        .quotient(q_in[7:0]), .remainder(r_in[7:0]), .div_by_zero(div_by_zero),
        .out_valid(out_valid8), .out_ready(out_ready), .q_sign(q_sign8), .q_bcd(q_bcd8),
        .r_sign(r_sign8), .r_bcd(r_bcd8), .err(err8)
    );

    logic        cur_in_ready, cur_out_valid, cur_q_sign, cur_r_sign, cur_err;
    logic [11:0] cur_q_bcd, cur_r_bcd;
    int          cur_w;

    assign cur_in_ready  = use8 ? in_ready8  : in_ready4;
    assign cur_out_valid = use8 ? out_valid8 : out_valid4;
    assign cur_q_sign    = use8 ? q_sign8    : q_sign4;
    assign cur_r_sign    = use8 ? r_sign8    : r_sign4;
    assign cur_err       = use8 ? err8       : err4;
    assign cur_q_bcd     = use8 ? q_bcd8     : {4'h0, q_bcd4};
    assign cur_r_bcd     = use8 ? r_bcd8     : {4'h0, r_bcd4};
    assign cur_w         = use8 ? 8 : 4;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Decimal digits of |v| computed arithmetically, packed four bits per digit.
    function automatic logic [31:0] ref_bcd(input int v);
        int m;
        logic [31:0] res;
        m = (v < 0) ? -v : v;
        res = '0;
        for (int i = 0; i < 8; i++) begin
            res[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return res;
    endfunction

    task automatic send(input int q, input int r, input logic dz);
        q_in = 16'(q);
        r_in = 16'(r);
        div_by_zero = dz;
        in_valid = 1'b1;
        check("in_ready_before_accept", cur_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        q_in = 16'($urandom);
        r_in = 16'($urandom);
        div_by_zero = 1'($urandom);
    endtask

    task automatic wait_out(input int exp_lat);
        int k;
        k = 0;
        while (!cur_out_valid && k < 64) begin
            @(negedge clk);
            k++;
        end
        check("latency", k, exp_lat);
    endtask

    task automatic check_out(input int q, input int r, input logic dz);
        check("out_valid", cur_out_valid, 1);
        check("in_ready_busy", cur_in_ready, 0);
        check("err", cur_err, dz);
        check("q_sign", cur_q_sign, dz ? 0 : (q < 0));
        check("r_sign", cur_r_sign, dz ? 0 : (r < 0));
        check("q_bcd", cur_q_bcd, dz ? 0 : ref_bcd(q));
        check("r_bcd", cur_r_bcd, dz ? 0 : ref_bcd(r));
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after_ack", cur_in_ready, 1);
        check("out_valid_after_ack", cur_out_valid, 0);
    endtask

    task automatic run(input int q, input int r, input logic dz);
        send(q, r, dz);
        wait_out(dz ? 1 : cur_w + 1);
        check_out(q, r, dz);
        release_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int q, r, half;
        logic dz;

        #1;
        check("rst_in_ready", in_ready4, 1);
        check("rst_out_valid", out_valid4, 0);
        check("rst_q_bcd", q_bcd4, 0);
        check("rst_err", err4, 0);
        check("rst_in_ready8", in_ready8, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Stray out_ready while idle must do nothing.
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("stray_ready_idle", cur_in_ready, 1);
        check("stray_ready_ov", cur_out_valid, 0);

        use8 = 1'b0;
        run(-3, -1, 1'b0);
        run(-8, 0, 1'b0);
        run(7, 3, 1'b0);
        run(-6, 5, 1'b1);
        run(1, 0, 1'b0);

        use8 = 1'b1;
        run(-128, 100, 1'b0);
        run(127, -99, 1'b0);
        use8 = 1'b0;

        // Backpressure: a second pair held on the input is ignored until idle.
        send(2, 1, 1'b0);
        wait_out(5);
        check_out(2, 1, 1'b0);
        q_in = 16'(-5);
        r_in = 16'(3);
        div_by_zero = 1'b0;
        in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", cur_out_valid, 1);
            check("bp_in_ready", cur_in_ready, 0);
            check("bp_q_bcd", cur_q_bcd, ref_bcd(2));
            check("bp_r_bcd", cur_r_bcd, ref_bcd(1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle", cur_in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(5);
        check_out(-5, 3, 1'b0);
        release_out();

        // Reset in the middle of a conversion.
        run(0, 4, 1'b1);
        send(-7, -2, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", cur_out_valid, 0);
        check("mid_rst_in_ready", cur_in_ready, 1);
        check("mid_rst_q_bcd", cur_q_bcd, 0);
        check("mid_rst_r_bcd", cur_r_bcd, 0);
        check("mid_rst_signs", {cur_q_sign, cur_r_sign}, 0);
        check("mid_rst_err", cur_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_out_valid", cur_out_valid, 0);
        run(5, 2, 1'b0);

        repeat (40) begin
            use8 = 1'($urandom_range(0, 1));
            half = use8 ? 128 : 8;
            q = int'($urandom_range(0, 2 * half - 1)) - half;
            r = int'($urandom_range(0, 2 * half - 1)) - half;
            dz = ($urandom_range(0, 7) == 0);
            run(q, r, dz);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
